lif_update_scheduler: RTL and testbench
=======================================

// Module: lif_update_scheduler
// PURPOSE
//  Sequences per-timestep membrane updates for N LIF neurons through one shared 16-bit signed
//  subtractor: leak, integrate, threshold-fire, spike reset. Holds the membrane register file.
//  Requests the subtractor with a req/gnt handshake so other users can share it.
//  Sits between the step/tick generator and the spike output encoder.
// PARAMETERS
//  N_NEURONS  4   neurons time-multiplexed (>=1); IDX_W = max(1,$clog2(N_NEURONS))
//  RESET_V    0   signed 16-bit membrane value loaded after a spike
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  step       in   1        timestep start pulse; sampled only in IDLE
//  leak       in   16       signed leak; sampled at accepted step
//  threshold  in   16       signed fire threshold; sampled at accepted step
//  cur_in     in   16*N     signed input current per neuron, neuron i at [16i+:16]; sampled at step
//  sub_req    out  1        subtractor request; high in LEAK/INTEG/FIRE
//  sub_gnt    in   1        subtractor granted this cycle; op completes only when req&gnt
//  sub_a      out  16       minuend to shared subtractor
//  sub_b      out  16       subtrahend to shared subtractor
//  sub_c      in   17       combinational result = sext(sub_a)-sext(sub_b), 17-bit two's complement
//  busy       out  1        state != IDLE
//  done       out  1        one-cycle pulse in DONE state
//  spike_out  out  N        spike vector of last completed timestep
//  step_drop  out  1        one-cycle pulse: step seen while busy (ignored)
//  v_rd_idx   in   IDX_W    membrane readback index
//  v_rd_data  out  16       V[v_rd_idx], combinational read of register file
// BEHAVIOUR
//  Reset: state IDLE, V[*]=0, spike_out=0, done=0, step_drop=0, sub_req=0, sub_a=sub_b=0, idx=0.
//  sat16(x17): >32767 -> 32767; < -32768 -> -32768; else x[15:0].
//  neg16(I): -I, with I=-32768 -> 32767.
//  IDLE : step -> latch leak/threshold/cur_in, idx=0, -> LEAK.
//  LEAK : a=V[idx], b=leak; on gnt T=sat16(c) -> INTEG.
//  INTEG: a=T, b=neg16(cur_in[idx]); on gnt T=sat16(c) -> FIRE.
//  FIRE : a=T, b=threshold; on gnt: c>=0 (c[16]==0) -> spike_nxt[idx]=1, V[idx]=RESET_V;
//         else spike_nxt[idx]=0, V[idx]=T. idx==N-1 -> DONE (spike_out<=spike_nxt), else idx++ -> LEAK.
//  DONE : done=1 for one cycle -> IDLE.
//  gnt low: state, idx, T, sub_a/sub_b held stable; sub_req stays high (no retraction).
//  Latency, gnt tied high: step at cycle t -> ops t+1..t+3N, done at t+3N+1, IDLE at t+3N+2.
//  step while busy (incl. DONE): ignored, step_drop pulses next cycle; latched operands unchanged.
//  spike_out changes only on entry to DONE; stable otherwise.
//  v_rd_data reflects updates the cycle after the FIRE write.
//  Reset mid-operation: immediate return to reset values; partial timestep discarded.
//  Threshold equality fires (V' == threshold -> spike).
// STRUCTURE
//  Package lif_sched_pkg: state enum {IDLE,LEAK,INTEG,FIRE,DONE}, SAT_MAX=16'sh7FFF,
//  SAT_MIN=16'sh8000, functions sat16/neg16.
//  One sub-module: lif_membrane_rf (N x 16 regs, 1 write port, 2 async read ports:
//  scheduler + readback, async reset to 0). FSM and operand mux stay in top.
// TESTING (N=4, RESET_V=0, gnt=1 unless stated)
//  1 Integrate: leak=10, thr=1000, cur=500 all; steps 1,2,3 -> V=490, 980, then spike_out=4'hF, V=0.
//  2 Saturation: leak=32767, cur0=-32768, V0=0 -> V0=-32768, no spike; cur0=32767, leak=-32768, V0=0 -> V0=32767.
//  3 Timing: single step at cycle t -> busy t+1..t+13, done only at t+13, sub_req high 12 cycles.
//  4 Stall: gnt low 5 cycles mid-INTEG on neuron 2 -> sub_a/sub_b stable, done delayed by exactly 5, results equal 1.
//  5 Boundary: thr=490 with case-1 inputs -> spike at step 1 (equality); step during busy -> step_drop pulse, one timestep only.
//  6 Reset: rst_n low in FIRE of neuron 1 -> all V=0, spike_out=0, IDLE; next step behaves as from power-up.

Source files
------------

// File: rtl/lif_update_scheduler_pkg.sv
// Shared types and arithmetic helpers for the LIF membrane update scheduler.
// The saturation helpers fold the shared 17-bit subtractor result back into 16 bits.
package lif_sched_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEAK  = 3'd1,
      INTEG = 3'd2,
      FIRE  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
   localparam logic signed [15:0] SAT_MIN = 16'sh8000;

   // Bits 16 and 15 differ exactly when the 17-bit value leaves the 16-bit range.
   function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
      logic signed [15:0] r;
      if (x[16] == x[15]) begin
         r = x[15:0];
      end else if (x[16]) begin
         r = SAT_MIN;
      end else begin
         r = SAT_MAX;
      end
      return r;
   endfunction

   function automatic logic signed [15:0] neg16(input logic signed [15:0] i);
      logic signed [15:0] r;
      if (i == SAT_MIN) begin
         r = SAT_MAX;
      end else begin
         r = -i;
      end
      return r;
   endfunction

endpackage

// File: rtl/lif_update_scheduler_if.sv
// Request/grant bus to the shared 16-bit signed subtractor.
interface lif_update_scheduler_if;
   // sub_req is the valid: once raised it stays high with sub_a/sub_b stable until
   // a cycle where sub_gnt (ready) is also high; that cycle's sub_c is consumed.
   logic        sub_req;
   logic        sub_gnt;
   logic [15:0] sub_a;
   logic [15:0] sub_b;
   logic [16:0] sub_c;

   modport master (
      output sub_req,
      output sub_a,
      output sub_b,
      input  sub_gnt,
      input  sub_c
   );

   modport slave (
      input  sub_req,
      input  sub_a,
      input  sub_b,
      output sub_gnt,
      output sub_c
   );
endinterface

// File: rtl/lif_membrane_rf.sv
// Membrane register file: N x 16-bit, one write port, two asynchronous read ports.
module lif_membrane_rf #(
   parameter int N_NEURONS = 4,
   parameter int IDX_W     = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [15:0]      wdata,
   input  logic [IDX_W-1:0] raddr_a,
   output logic [15:0]      rdata_a,
   input  logic [IDX_W-1:0] raddr_b,
   output logic [15:0]      rdata_b
);

   logic [15:0] mem [N_NEURONS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (int'(waddr) < N_NEURONS)) begin
         mem[waddr] <= wdata;
      end
   end

   // Indices past N_NEURONS (non power-of-two N) read as zero.
   assign rdata_a = (int'(raddr_a) < N_NEURONS) ? mem[raddr_a] : '0;
   assign rdata_b = (int'(raddr_b) < N_NEURONS) ? mem[raddr_b] : '0;

endmodule

// File: rtl/lif_update_scheduler.sv
// Per-timestep LIF update sequencer: leak, integrate, fire for each neuron in turn,
// sharing one external subtractor through a req/gnt bus.
module lif_update_scheduler
   import lif_sched_pkg::*;
#(
   parameter int                 N_NEURONS = 4,
   parameter logic signed [15:0] RESET_V   = 16'sd0,
   localparam int                IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      step,
   input  logic [15:0]               leak,
   input  logic [15:0]               threshold,
   input  logic [16*N_NEURONS-1:0]   cur_in,
   lif_update_scheduler_if.master    sub,
   output logic                      busy,
   output logic                      done,
   output logic [N_NEURONS-1:0]      spike_out,
   output logic                      step_drop,
   input  logic [IDX_W-1:0]          v_rd_idx,
   output logic [15:0]               v_rd_data,
   output state_t                    dbg_state
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

   state_t                    state;
   state_t                    state_nxt;
   logic [IDX_W-1:0]          idx;
   logic signed [15:0]        t_q;
   logic signed [15:0]        leak_q;
   logic signed [15:0]        thr_q;
   logic signed [15:0]        cur_q [N_NEURONS];
   logic [N_NEURONS-1:0]      spike_nxt_q;
   logic [N_NEURONS-1:0]      spike_upd;
   logic [15:0]               v_sched;
   logic                      sub_req_c;
   logic [15:0]               sub_a_c;
   logic [15:0]               sub_b_c;
   logic                      fire;
   logic                      rf_we;
   logic [15:0]               rf_wdata;

   lif_membrane_rf #(
      .N_NEURONS (N_NEURONS),
      .IDX_W     (IDX_W)
   ) u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (rf_we),
      .waddr   (idx),
      .wdata   (rf_wdata),
      .raddr_a (idx),
      .rdata_a (v_sched),
      .raddr_b (v_rd_idx),
      .rdata_b (v_rd_data)
   );

   // T - threshold is non-negative exactly when the sign bit is clear, so equality fires.
   assign fire     = ~sub.sub_c[16];
   assign rf_we    = (state == FIRE) && sub.sub_gnt;
   assign rf_wdata = fire ? RESET_V : t_q;

   always_comb begin
      state_nxt = state;
      sub_req_c = 1'b0;
      sub_a_c   = '0;
      sub_b_c   = '0;
      case (state)
         IDLE: begin
            if (step) state_nxt = LEAK;
         end
         LEAK: begin
            sub_req_c = 1'b1;
            sub_a_c   = v_sched;
            sub_b_c   = leak_q;
            if (sub.sub_gnt) state_nxt = INTEG;
         end
         INTEG: begin
            sub_req_c = 1'b1;
            sub_a_c   = t_q;
            sub_b_c   = neg16(cur_q[idx]);
            if (sub.sub_gnt) state_nxt = FIRE;
         end
         FIRE: begin
            sub_req_c = 1'b1;
            sub_a_c   = t_q;
            sub_b_c   = thr_q;
            if (sub.sub_gnt) state_nxt = (idx == LAST_IDX) ? DONE : LEAK;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      spike_upd      = spike_nxt_q;
      spike_upd[idx] = fire;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         t_q         <= '0;
         leak_q      <= '0;
         thr_q       <= '0;
         spike_nxt_q <= '0;
         spike_out   <= '0;
         step_drop   <= 1'b0;
         for (int i = 0; i < N_NEURONS; i++) begin
            cur_q[i] <= '0;
         end
      end else begin
         state     <= state_nxt;
         step_drop <= step && (state != IDLE);
         case (state)
            IDLE: begin
               if (step) begin
                  leak_q <= leak;
                  thr_q  <= threshold;
                  idx    <= '0;
                  for (int i = 0; i < N_NEURONS; i++) begin
                     cur_q[i] <= cur_in[16*i +: 16];
                  end
               end
            end
            LEAK, INTEG: begin
               if (sub.sub_gnt) t_q <= sat16($signed(sub.sub_c));
            end
            FIRE: begin
               if (sub.sub_gnt) begin
                  spike_nxt_q <= spike_upd;
                  // The visible spike vector only moves once the whole timestep is in.
                  if (idx == LAST_IDX) begin
                     spike_out <= spike_upd;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign sub.sub_req = sub_req_c;
   assign sub.sub_a   = sub_a_c;
   assign sub.sub_b   = sub_b_c;
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign dbg_state   = state;

endmodule

// File: tb/tb_lif_update_scheduler.sv
// Directed bench for lif_update_scheduler: driver issues timesteps and pushes hand-computed
// results; a monitor pops them on done (or on request while idle) and checks spikes and V.
module tb_lif_update_scheduler;
  import lif_sched_pkg::*;

  localparam int N     = 4;
  localparam int EXP_W = 4 + 16 * N;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          step;
  logic [15:0]   leak;
  logic [15:0]   threshold;
  logic [16*N-1:0] cur_in;
  logic          busy;
  logic          done;
  logic [N-1:0]  spike_out;
  logic          step_drop;
  logic [1:0]    v_rd_idx;
  logic [15:0]   v_rd_data;
  state_t        dbg_state;
  logic          gnt;

  always #5 clk = ~clk;

  lif_update_scheduler_if sub_bus ();

  // Shared subtractor model: sign-extend both operands to 17 bits.
  assign sub_bus.sub_c   = {sub_bus.sub_a[15], sub_bus.sub_a} - {sub_bus.sub_b[15], sub_bus.sub_b};
  assign sub_bus.sub_gnt = gnt;

  lif_update_scheduler #(
    .N_NEURONS (N),
    .RESET_V   (16'sd0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .step      (step),
    .leak      (leak),
    .threshold (threshold),
    .cur_in    (cur_in),
    .sub       (sub_bus),
    .busy      (busy),
    .done      (done),
    .spike_out (spike_out),
    .step_drop (step_drop),
    .v_rd_idx  (v_rd_idx),
    .v_rd_data (v_rd_data),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic snap_tog = 1'b0;
  logic snap_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EXP_W-1:0] pack_exp(input logic [3:0] spk, input logic [15:0] v0,
                                                input logic [15:0] v1, input logic [15:0] v2,
                                                input logic [15:0] v3);
    return {spk, v3, v2, v1, v0};
  endfunction

  task automatic compare_item(input logic [EXP_W-1:0] e);
    check("spike_out", {28'd0, spike_out}, {28'd0, e[EXP_W-1 -: 4]});
    for (int i = 0; i < N; i++) begin
      v_rd_idx = 2'(i);
      #1;
      check($sformatf("v%0d", i), {16'd0, v_rd_data}, {16'd0, e[16*i +: 16]});
    end
  endtask

  // Monitor: consumes one expected entry per done pulse or per idle snapshot request.
  initial begin
    v_rd_idx = '0;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1 expected no timestep (t=%0t)", $time);
        end else begin
          compare_item(exp_q.pop_front());
        end
      end else if (snap_tog != snap_ack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL snap_empty: got empty queue expected an entry (t=%0t)", $time);
        end else begin
          compare_item(exp_q.pop_front());
        end
        snap_ack = snap_tog;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int r_busy, r_req, r_done, r_done_cnt, r_drop, r_drop_cyc, r_spk_bad;
  logic [15:0] r_probe_a, r_probe_b;

  task automatic reset_dut();
    rst_n = 1'b0;
    gnt   = 1'b1;
    step  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic snap(input logic [EXP_W-1:0] e);
    exp_q.push_back(e);
    snap_tog = ~snap_tog;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (snap_ack == snap_tog) break;
    end
    if (snap_ack != snap_tog) begin
      n_checks++;
      n_errors++;
      $display("FAIL snap_timeout: got no monitor response expected one within 6 cycles");
      snap_ack = snap_tog;
    end
  endtask

  // One timestep; cycle k is the k-th cycle after the edge that samples step.
  task automatic run_step(input logic [15:0] lk, input logic [15:0] th, input logic [63:0] cur,
                          input int stall_at, input int stall_len, input int drop_at,
                          input int rst_at, input int probe_at);
    logic [15:0] a_hold, b_hold;
    logic [3:0]  spk_prev;
    r_busy = 0; r_req = 0; r_done = 0; r_done_cnt = 0;
    r_drop = 0; r_drop_cyc = 0; r_spk_bad = 0;
    a_hold = '0; b_hold = '0;
    @(negedge clk);
    leak = lk; threshold = th; cur_in = cur; step = 1'b1;
    spk_prev = spike_out;
    for (int k = 1; k <= 24 + stall_len; k++) begin
      @(negedge clk);
      if (k == 1) step = 1'b0;
      if (busy) r_busy++;
      if (sub_bus.sub_req) r_req++;
      if (done) begin r_done_cnt++; r_done = k; end
      if (step_drop) begin r_drop++; r_drop_cyc = k; end
      if (spike_out !== spk_prev && !done) r_spk_bad++;
      spk_prev = spike_out;
      if (k == probe_at) begin
        r_probe_a = sub_bus.sub_a;
        r_probe_b = sub_bus.sub_b;
      end
      if (stall_len > 0) begin
        if (k == stall_at) begin
          check("stall_state", 32'(dbg_state), 32'(INTEG));
          a_hold = sub_bus.sub_a;
          b_hold = sub_bus.sub_b;
          gnt = 1'b0;
        end else if (k > stall_at && k <= stall_at + stall_len) begin
          check("stall_a", {16'd0, sub_bus.sub_a}, {16'd0, a_hold});
          check("stall_b", {16'd0, sub_bus.sub_b}, {16'd0, b_hold});
          check("stall_req", {31'd0, sub_bus.sub_req}, 32'd1);
          if (k == stall_at + stall_len) gnt = 1'b1;
        end
      end
      if (drop_at > 0 && k == drop_at) begin
        step = 1'b1;
        leak = 16'h0100; threshold = 16'h7FFF; cur_in = '0;
      end
      if (drop_at > 0 && k == drop_at + 1) step = 1'b0;
      if (rst_at > 0 && k == rst_at) begin
        check("rst_in_fire", 32'(dbg_state), 32'(FIRE));
        rst_n = 1'b0;
        #1;
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_spike", {28'd0, spike_out}, 32'd0);
        check("rst_req", {31'd0, sub_bus.sub_req}, 32'd0);
        check("rst_sub_a", {16'd0, sub_bus.sub_a}, 32'd0);
      end
      if (rst_at > 0 && k == rst_at + 1) rst_n = 1'b1;
    end
  endtask

  task automatic check_timing(input string tag, input int busy_exp, input int req_exp,
                              input int done_exp);
    check({tag, "_busy_cycles"}, 32'(r_busy), 32'(busy_exp));
    check({tag, "_req_cycles"}, 32'(r_req), 32'(req_exp));
    check({tag, "_done_cycle"}, 32'(r_done), 32'(done_exp));
    check({tag, "_done_count"}, 32'(r_done_cnt), 32'd1);
    check({tag, "_spike_stable"}, 32'(r_spike_bad_get()), 32'd0);
  endtask

  function automatic int r_spike_bad_get();
    return r_spk_bad;
  endfunction

  // ---------------- directed sequence ----------------
  localparam logic [63:0] CUR500 = {4{16'd500}};

  initial begin
    rst_n = 1'b0; step = 1'b0; gnt = 1'b1;
    leak = '0; threshold = '0; cur_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_drop", {31'd0, step_drop}, 32'd0);
    check("reset_req", {31'd0, sub_bus.sub_req}, 32'd0);
    check("reset_sub_a", {16'd0, sub_bus.sub_a}, 32'd0);
    check("reset_sub_b", {16'd0, sub_bus.sub_b}, 32'd0);
    snap(pack_exp(4'h0, 16'd0, 16'd0, 16'd0, 16'd0));

    // Integrate over three steps, plus latency with gnt tied high
    exp_q.push_back(pack_exp(4'h0, 16'd490, 16'd490, 16'd490, 16'd490));
    run_step(16'd10, 16'd1000, CUR500, 0, 0, 0, 0, 0);
    check_timing("t1", 13, 12, 13);
    exp_q.push_back(pack_exp(4'h0, 16'd980, 16'd980, 16'd980, 16'd980));
    run_step(16'd10, 16'd1000, CUR500, 0, 0, 0, 0, 0);
    exp_q.push_back(pack_exp(4'hF, 16'd0, 16'd0, 16'd0, 16'd0));
    run_step(16'd10, 16'd1000, CUR500, 0, 0, 0, 0, 0);
    check_timing("t1_fire", 13, 12, 13);

    // Negative saturation: 0 - 32767 = -32767, then -32767 - 32767 saturates
    reset_dut();
    exp_q.push_back(pack_exp(4'h0, 16'h8000, 16'h8001, 16'h8001, 16'h8001));
    run_step(16'h7FFF, 16'd1000, {16'h0000, 16'h0000, 16'h0000, 16'h8000}, 0, 0, 0, 0, 2);
    check("neg16_min_b", {16'd0, r_probe_b}, 32'h7FFF);
    check("leak_T_a", {16'd0, r_probe_a}, 32'h8001);

    // Positive saturation: T reaches 32767, which then meets a 32767 threshold
    reset_dut();
    exp_q.push_back(pack_exp(4'hF, 16'd0, 16'd0, 16'd0, 16'd0));
    run_step(16'h8000, 16'h7FFF, {16'h0000, 16'h0000, 16'h0000, 16'h7FFF}, 0, 0, 0, 0, 3);
    check("sat_pos_T", {16'd0, r_probe_a}, 32'h7FFF);
    check("sat_pos_thr", {16'd0, r_probe_b}, 32'h7FFF);

    // Grant stall of 5 cycles in INTEG of neuron 2
    reset_dut();
    exp_q.push_back(pack_exp(4'h0, 16'd490, 16'd490, 16'd490, 16'd490));
    run_step(16'd10, 16'd1000, CUR500, 8, 5, 0, 0, 0);
    check_timing("stall", 18, 17, 18);

    // Threshold equality fires
    reset_dut();
    exp_q.push_back(pack_exp(4'hF, 16'd0, 16'd0, 16'd0, 16'd0));
    run_step(16'd10, 16'd490, CUR500, 0, 0, 0, 0, 0);
    check_timing("eq", 13, 12, 13);

    // Step while busy (mid-timestep, then in DONE): dropped, operands untouched
    exp_q.push_back(pack_exp(4'hF, 16'd0, 16'd0, 16'd0, 16'd0));
    run_step(16'd10, 16'd490, CUR500, 0, 0, 5, 0, 0);
    check_timing("drop_mid", 13, 12, 13);
    check("drop_mid_count", 32'(r_drop), 32'd1);
    check("drop_mid_cycle", 32'(r_drop_cyc), 32'd6);
    exp_q.push_back(pack_exp(4'hF, 16'd0, 16'd0, 16'd0, 16'd0));
    run_step(16'd10, 16'd490, CUR500, 0, 0, 13, 0, 0);
    check_timing("drop_done", 13, 12, 13);
    check("drop_done_count", 32'(r_drop), 32'd1);
    check("drop_done_cycle", 32'(r_drop_cyc), 32'd14);

    // Reset in FIRE of neuron 1 after neuron 0 already wrote 490
    run_step(16'd10, 16'd1000, CUR500, 0, 0, 0, 6, 0);
    check("rst_no_done", 32'(r_done_cnt), 32'd0);
    check("rst_idle_after", 32'(dbg_state), 32'(IDLE));
    snap(pack_exp(4'h0, 16'd0, 16'd0, 16'd0, 16'd0));
    exp_q.push_back(pack_exp(4'h0, 16'd490, 16'd490, 16'd490, 16'd490));
    run_step(16'd10, 16'd1000, CUR500, 0, 0, 0, 0, 0);
    check_timing("post_rst", 13, 12, 13);

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
